// File: rtl/datapath_pkg.sv
// datapath_pkg: ALU opcode encodings shared by the datapath and its ALU
package datapath_pkg;
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_SLTU = 4'b1011;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
endpackage

// File: rtl/alu_param.sv
// alu_param: combinational XLEN-wide ALU; undefined opcodes yield 0
module alu_param
  import datapath_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      op,
  output logic [XLEN-1:0] y
);
  localparam int SW = $clog2(XLEN);
  logic [SW-1:0] sh;
  assign sh = b[SW-1:0];
  // Opcode decode; shifts use only the low log2(XLEN) bits of b
  always_comb begin
    case (op)
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_ADD:  y = a + b;
      ALU_XOR:  y = a ^ b;
      ALU_SUB:  y = a - b;
      ALU_SLT:  y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: y = {{(XLEN-1){1'b0}}, a < b};
      ALU_NOR:  y = ~(a | b);
      ALU_SLL:  y = a << sh;
      ALU_SRL:  y = a >> sh;
      ALU_SRA:  y = $signed(a) >>> sh;
      default:  y = '0;
    endcase
  end
endmodule

// File: rtl/pipelined_datapath.sv
// pipelined_datapath: register file + two-stage (EX/WB) ALU pipeline with full forwarding
module pipelined_datapath #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int RAW  = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [RAW-1:0]  read_reg1,
  input  logic [RAW-1:0]  read_reg2,
  input  logic [RAW-1:0]  write_reg,
  input  logic [3:0]      alu_control,
  input  logic            use_imm,
  input  logic [XLEN-1:0] imm,
  input  logic            write_on_register,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            zero_flag,
  output logic [RAW-1:0]  out_write_reg
);
  logic [XLEN-1:0] rf [NREGS];
  logic            ex_valid, ex_wen;
  logic [XLEN-1:0] ex_a, ex_b;
  logic [3:0]      ex_op;
  logic [RAW-1:0]  ex_dest;
  logic            wb_valid, wb_wen, wb_zero;
  logic [XLEN-1:0] wb_result;
  logic [RAW-1:0]  wb_dest;
  logic [XLEN-1:0] alu_y, opa, opb;
  logic            wb_adv, ex_adv, retire;
  alu_param #(.XLEN(XLEN)) u_alu (.a(ex_a), .b(ex_b), .op(ex_op), .y(alu_y));
  assign wb_adv = !wb_valid || out_ready;
  assign ex_adv = !ex_valid || wb_adv;
  assign in_ready = ex_adv;
  assign retire = wb_valid && out_ready && wb_wen;
  assign out_valid = wb_valid;
  assign out_result = wb_result;
  assign zero_flag = wb_zero;
  assign out_write_reg = wb_dest;
  // Operand capture: EX (younger) beats WB beats the committed register file; x0 is never forwarded
  assign opa = read_reg1 == '0 ? '0
             : ex_valid && ex_wen && ex_dest == read_reg1 ? alu_y
             : wb_valid && wb_wen && wb_dest == read_reg1 ? wb_result
             : rf[read_reg1];
  assign opb = use_imm ? imm
             : read_reg2 == '0 ? '0
             : ex_valid && ex_wen && ex_dest == read_reg2 ? alu_y
             : wb_valid && wb_wen && wb_dest == read_reg2 ? wb_result
             : rf[read_reg2];
  // Register file holds committed state only; written at the retire handshake, x0 writes dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    else if (retire && wb_dest != '0)
      rf[wb_dest] <= wb_result;
  end
  // EX and WB pipeline registers advancing under the valid/ready rules
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid  <= 1'b0;
      ex_wen    <= 1'b0;
      ex_a      <= '0;
      ex_b      <= '0;
      ex_op     <= '0;
      ex_dest   <= '0;
      wb_valid  <= 1'b0;
      wb_wen    <= 1'b0;
      wb_zero   <= 1'b0;
      wb_result <= '0;
      wb_dest   <= '0;
    end else begin
      if (ex_adv) ex_valid <= in_valid;
      if (ex_adv && in_valid) begin
        ex_a    <= opa;
        ex_b    <= opb;
        ex_op   <= alu_control;
        ex_dest <= write_reg;
        ex_wen  <= write_on_register;
      end
      if (wb_adv) wb_valid <= ex_valid;
      if (wb_adv && ex_valid) begin
        wb_result <= alu_y;
        wb_zero   <= alu_y == '0;
        wb_dest   <= ex_dest;
        wb_wen    <= ex_wen;
      end
    end
  end
endmodule

// File: doc/pipelined_datapath.md
# pipelined_datapath

Parametrised two-stage execute datapath: a register file of NREGS × XLEN words feeding an ALU through an operand-capture stage and a result stage, with full forwarding, an immediate operand path, and valid/ready handshakes at both ends. It is the next generation of the single-cycle register-block-plus-ALU datapath. It sits between decode, which drives the request side, and the top level, which consumes results and flags.

## Interface
- XLEN, 32, data width; power of two, ≥ 8
- NREGS, 32, register count; power of two, ≥ 2; RAW = log2(NREGS)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  request present
- in_ready  out  1  request accepted when in_valid && in_ready
- read_reg1, read_reg2  in  RAW  source register indices
- write_reg  in  RAW  destination index
- alu_control  in  4  ALU operation
- use_imm  in  1  operand B = imm instead of read_reg2 data
- imm  in  XLEN  immediate operand
- write_on_register  in  1  result is written to write_reg at retire
- out_valid  out  1  result present
- out_ready  in  1  result consumed when out_valid && out_ready
- out_result  out  XLEN  ALU result
- zero_flag  out  1  out_result == 0
- out_write_reg  out  RAW  destination of the presented result

## Operation
- Stages: EX (latched operands A/B, op, dest, wen, valid) and WB (latched result, zero, dest, wen, valid). The ALU is combinational between EX and WB.
- Register 0 always reads 0. A write to it is discarded, and it is never a forwarding source.
- Operand capture at accept, priority per source:
  - EX entry, if valid, wen set and dest matches: live ALU output.
  - Otherwise the WB entry, if valid, wen set and dest matches: its result.
  - Otherwise the register file.
- With use_imm set, B = imm and read_reg2 is ignored.
- Commit: the register file is written with the WB result at the retire edge (out_valid && out_ready && wen). The register file holds committed state only.
- ALU codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0110 SUB, 0111 SLT (signed), 1011 SLTU, 1100 NOR
  - 1000 SLL, 1001 SRL, 1010 SRA
  - Shifts use B[log2(XLEN)-1:0].
  - SLT/SLTU produce 0 or 1, zero-extended.
  - ADD/SUB wrap modulo 2^XLEN; carry is discarded.
  - Undefined codes produce 0, so zero_flag = 1.
- zero_flag is registered alongside out_result and never computed from later data.

## Timing
- Reset (async assert; deassert sampled on clk):
  - All register-file entries = 0.
  - EX/WB valid = 0.
  - out_result = 0, zero_flag = 0, out_write_reg = 0, out_valid = 0.
  - in_ready = 1.
- Advance rules:
  - wb_adv = !WB.valid || out_ready
  - ex_adv = !EX.valid || wb_adv
  - in_ready = ex_adv (combinational)
- Latency: a request accepted at edge N presents out_valid after edge N+1 when out_ready is held high.
- Throughput: one result per cycle with no stall for any dependency chain.
- Backpressure: while out_valid && !out_ready, WB holds and out_result/zero_flag/out_write_reg are stable. EX holds if full, and in_ready drops.
- Retire and accept in the same cycle, with the request reading the retiring dest: forwarding from WB applies, giving the new value.
- If both EX and WB match the dest, EX (younger) wins.
- Reset mid-operation: in-flight entries are dropped, no commit occurs, and the register file clears.

## Structure
- Package datapath_pkg holds the ALU opcode localparams (ALU_AND … ALU_SRA).
- Sub-module alu_param (XLEN): combinational result only. The register file, forwarding and pipeline registers live in pipelined_datapath.
- Register file: NREGS × XLEN flops with an async-reset clear, two combinational read ports and one write port.

## Test plan
- Reset, then check: in_ready=1, out_valid=0, out_result=0; reading x1..x31 via ADD with use_imm=1 and imm=0 returns 0 each.
- ADD x1 ← x0 + imm 5, then ADD x2 ← x1 + x1 on the next cycle with out_ready=1 -> results 5 then 10; x2 commits 10 with no stall.
- SUB x3 ← x1 − imm 5 -> out_result=0, zero_flag=1. Then SLT with A = 0x8000_0000, B = 1 -> 1; SLTU with the same operands -> 0.
- out_ready low for 3 cycles with 3 requests offered -> out_result stable, in_ready=0 after EX fills; release -> results in order with none lost or duplicated.
- Write x0 ← imm 0xFFFF_FFFF, then ADD x4 ← x0 + x0 -> 0 (x0 not forwarded).
- Assert reset with EX and WB full -> out_valid=0 immediately, no commit occurs, and a later read of the pending dest returns 0.
